// File: rtl/ysyx_23060075_mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Covers FSM states, master ids, bus widths and the latched request record.
package ysyx_23060075_mem_arb_pkg;
   localparam int ISA_WIDTH      = 32;
   localparam int MEM_MASK_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      MID_M1 = 1'b0,
      MID_M2 = 1'b1
   } mid_t;

   typedef struct packed {
      logic [ISA_WIDTH-1:0]      addr;
      logic [ISA_WIDTH-1:0]      wdata;
      logic [MEM_MASK_WIDTH-1:0] mask;
      logic                      wen;
   } mem_req_t;

   // Counter width able to hold n; at least one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/ysyx_23060075_mem_arb_if.sv
// Request/response memory bus; the master issues requests, the slave answers.
// The arbiter is a slave towards each CPU master and a master towards memory.
interface ysyx_23060075_mem_arb_if;
   import ysyx_23060075_mem_arb_pkg::*;

   logic                      req_valid;
   logic                      req_ready;
   logic [ISA_WIDTH-1:0]      addr;
   logic [ISA_WIDTH-1:0]      wdata;
   logic [MEM_MASK_WIDTH-1:0] mask;
   logic                      wen;
   logic                      resp_valid;
   logic [ISA_WIDTH-1:0]      rdata;
   logic                      resp_err;

   modport master (
      output req_valid, addr, wdata, mask, wen,
      input  req_ready, resp_valid, rdata, resp_err
   );

   modport slave (
      input  req_valid, addr, wdata, mask, wen,
      output req_ready, resp_valid, rdata, resp_err
   );
endinterface

// File: rtl/ysyx_23060075_rr_arb2.sv
// Two-way round-robin grant with its last-grant register.
// A lone requester always wins; on a tie the master not granted last wins.
module ysyx_23060075_rr_arb2
   import ysyx_23060075_mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req1,
   input  logic req2,
   output logic gnt_valid,
   output mid_t gnt_id
);
   mid_t last;

   always_comb begin
      gnt_valid = en & (req1 | req2);
      if (req1 & req2)
         gnt_id = (last == MID_M2) ? MID_M1 : MID_M2;
      else if (req2)
         gnt_id = MID_M2;
      else
         gnt_id = MID_M1;
   end

   // Reset to m2 so m1 takes the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last <= MID_M2;
      else if (gnt_valid)
         last <= gnt_id;
   end
endmodule

// File: rtl/ysyx_23060075_mem_arb.sv
// Shares one memory slave between fetch (m1) and load/store (m2).
// One transaction in flight: IDLE grants, REQ presents it, WAIT collects the reply or times out.
module ysyx_23060075_mem_arb
   import ysyx_23060075_mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   ysyx_23060075_mem_arb_if.slave  m1,
   ysyx_23060075_mem_arb_if.slave  m2,
   ysyx_23060075_mem_arb_if.master s
);
   localparam int              CW       = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   arb_state_t    state;
   mid_t          gnt;
   logic [CW-1:0] cnt;
   logic          gnt_valid;
   mid_t          gnt_id;
   mem_req_t      sel;
   logic          timeout_hit;
   logic          unused_ok;

   ysyx_23060075_rr_arb2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .en        (state == ST_IDLE && !rst),
      .req1      (m1.req_valid),
      .req2      (m2.req_valid),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign m1.req_ready = gnt_valid && (gnt_id == MID_M1);
   assign m2.req_ready = gnt_valid && (gnt_id == MID_M2);

   // Fetches are always plain reads: store fields forced to zero.
   always_comb begin
      sel = '0;
      if (gnt_id == MID_M1) begin
         sel.addr = m1.addr;
      end else begin
         sel.addr  = m2.addr;
         sel.wdata = m2.wdata;
         sel.mask  = m2.mask;
         sel.wen   = m2.wen;
      end
   end

   // The reply is checked first, so a response on the timeout cycle wins.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
   assign unused_ok   = ^{m1.wdata, m1.mask, m1.wen, s.resp_err};

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         gnt           <= MID_M1;
         cnt           <= '0;
         s.req_valid   <= 1'b0;
         s.addr        <= '0;
         s.wdata       <= '0;
         s.mask        <= '0;
         s.wen         <= 1'b0;
         m1.resp_valid <= 1'b0;
         m1.resp_err   <= 1'b0;
         m1.rdata      <= '0;
         m2.resp_valid <= 1'b0;
         m2.resp_err   <= 1'b0;
         m2.rdata      <= '0;
      end else begin
         m1.resp_valid <= 1'b0;
         m1.resp_err   <= 1'b0;
         m2.resp_valid <= 1'b0;
         m2.resp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  gnt         <= gnt_id;
                  s.addr      <= sel.addr;
                  s.wdata     <= sel.wdata;
                  s.mask      <= sel.mask;
                  s.wen       <= sel.wen;
                  s.req_valid <= 1'b1;
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (s.req_ready) begin
                  s.req_valid <= 1'b0;
                  cnt         <= '0;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (s.resp_valid || timeout_hit) begin
                  if (gnt == MID_M1) begin
                     m1.resp_valid <= 1'b1;
                     m1.resp_err   <= !s.resp_valid;
                     m1.rdata      <= s.resp_valid ? s.rdata : '0;
                  end else begin
                     m2.resp_valid <= 1'b1;
                     m2.resp_err   <= !s.resp_valid;
                     m2.rdata      <= s.resp_valid ? s.rdata : '0;
                  end
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_23060075_mem_arb.sv
// Randomized bench for the memory arbiter against a transaction-level model.
// Model: round-robin tie rule, fixed handshake latency, reply-or-timeout arithmetic.
module tb_ysyx_23060075_mem_arb;
   import ysyx_23060075_mem_arb_pkg::*;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   last_m2 = 1'b1;
   logic [31:0] exp_rd1 = '0;
   logic [31:0] exp_rd2 = '0;

   ysyx_23060075_mem_arb_if m1_bus ();
   ysyx_23060075_mem_arb_if m2_bus ();
   ysyx_23060075_mem_arb_if s_bus ();

   ysyx_23060075_mem_arb #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .m1  (m1_bus),
      .m2  (m2_bus),
      .s   (s_bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic out_any();
      return m1_bus.req_ready | m2_bus.req_ready | m1_bus.resp_valid | m2_bus.resp_valid |
             m1_bus.resp_err | m2_bus.resp_err | (|m1_bus.rdata) | (|m2_bus.rdata) |
             s_bus.req_valid | (|s_bus.addr) | (|s_bus.wdata) | (|s_bus.mask) | s_bus.wen;
   endfunction

   // One transaction starting in an IDLE cycle; v1/v2 select who requests.
   task automatic do_txn(input bit v1, input bit v2, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] wd, input logic [3:0] mk, input bit we,
                         input int rdy, input int rsp, input logic [31:0] rd);
      bit win2, got, exp_err;
      logic [31:0] ea, ewd, exp_data;
      logic [3:0] emk;
      bit ewe;
      int w, exp_lat;
      win2 = (v1 && v2) ? !last_m2 : v2;
      m1_bus.req_valid = v1;  m1_bus.addr = a1;  m1_bus.wdata = $urandom;
      m1_bus.mask = 4'hF;     m1_bus.wen = 1'b1;
      m2_bus.req_valid = v2;  m2_bus.addr = a2;  m2_bus.wdata = wd;
      m2_bus.mask = mk;       m2_bus.wen = we;
      #1;
      checks++;
      if (m1_bus.req_ready !== !win2 || m2_bus.req_ready !== win2) begin
         errors++;
         $display("FAIL grant_ready got m1=%b m2=%b want m1=%b m2=%b",
                  m1_bus.req_ready, m2_bus.req_ready, !win2, win2);
      end
      last_m2 = win2;
      ea  = win2 ? a2 : a1;
      ewd = win2 ? wd : 32'h0;
      emk = win2 ? mk : 4'h0;
      ewe = win2 ? we : 1'b0;
      step();
      m1_bus.req_valid = 1'b0;  m2_bus.req_valid = 1'b0;
      m1_bus.addr = $urandom;   m2_bus.addr = $urandom;  m2_bus.wdata = $urandom;
      for (int k = 0; k <= rdy; k++) begin
         checks++;
         if (s_bus.req_valid !== 1'b1 || s_bus.addr !== ea || s_bus.wdata !== ewd ||
             s_bus.mask !== emk || s_bus.wen !== ewe) begin
            errors++;
            $display("FAIL s_req cyc%0d got v=%b a=%h d=%h m=%h w=%b want v=1 a=%h d=%h m=%h w=%b",
                     k, s_bus.req_valid, s_bus.addr, s_bus.wdata, s_bus.mask, s_bus.wen,
                     ea, ewd, emk, ewe);
         end
         s_bus.req_ready  = (k == rdy);
         s_bus.resp_valid = 1'($urandom_range(0, 1));
         s_bus.rdata      = $urandom;
         step();
      end
      s_bus.req_ready  = 1'b0;
      s_bus.resp_valid = 1'b0;
      checks++;
      if (s_bus.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL s_req_drop got %b want 0", s_bus.req_valid);
      end
      exp_err  = !(rsp < TO);
      exp_lat  = exp_err ? TO : rsp + 1;
      exp_data = exp_err ? 32'h0 : rd;
      w = 0;
      got = 1'b0;
      while (!got && w < 40) begin
         if (m1_bus.resp_valid === 1'b1 || m2_bus.resp_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            s_bus.resp_valid = (w == rsp);
            s_bus.rdata      = (w == rsp) ? rd : $urandom;
            step();
            w++;
         end
      end
      s_bus.resp_valid = 1'b0;
      checks++;
      if (!got || w != exp_lat) begin
         errors++;
         $display("FAIL resp_latency got %0d (seen=%b) want %0d", w, got, exp_lat);
      end
      checks++;
      if (m1_bus.resp_valid !== !win2 || m2_bus.resp_valid !== win2) begin
         errors++;
         $display("FAIL resp_owner got m1=%b m2=%b want m1=%b m2=%b",
                  m1_bus.resp_valid, m2_bus.resp_valid, !win2, win2);
      end
      if (win2) exp_rd2 = exp_data;
      else      exp_rd1 = exp_data;
      checks++;
      if (m1_bus.rdata !== exp_rd1 || m2_bus.rdata !== exp_rd2) begin
         errors++;
         $display("FAIL rdata got m1=%h m2=%h want m1=%h m2=%h",
                  m1_bus.rdata, m2_bus.rdata, exp_rd1, exp_rd2);
      end
      checks++;
      if ((win2 ? m2_bus.resp_err : m1_bus.resp_err) !== exp_err) begin
         errors++;
         $display("FAIL resp_err got %b want %b",
                  win2 ? m2_bus.resp_err : m1_bus.resp_err, exp_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m1_bus.req_valid = 1'b1;
      m2_bus.req_valid = 1'b1;
      step();
      step();
      checks++;
      if (out_any() !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got nonzero output want all 0");
      end
      m1_bus.req_valid = 1'b0;
      m2_bus.req_valid = 1'b0;
      rst = 1'b0;
      last_m2 = 1'b1;
      exp_rd1 = '0;
      exp_rd2 = '0;
   endtask

   task automatic test_basic();
      do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0000_0413);
   endtask

   task automatic test_arb();
      for (int i = 0; i < 4; i++)
         do_txn(1'b1, 1'b1, 32'h8000_0000 + 32'(i * 4), 32'h8000_2000 + 32'(i * 4),
                $urandom, 4'($urandom), 1'($urandom), 0, 0, $urandom);
      // Lone requester wins regardless of last grant.
      do_txn(1'b0, 1'b1, 32'h0, 32'h8000_3000, 32'h0, 4'hF, 1'b0, 0, 1, $urandom);
      do_txn(1'b1, 1'b0, 32'h8000_0100, 32'h0, 32'h0, 4'h0, 1'b0, 1, 0, $urandom);
   endtask

   task automatic test_store();
      do_txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 5, 2, 32'h0);
   endtask

   task automatic test_timeout();
      do_txn(1'b0, 1'b1, 32'h0, 32'h8000_4000, 32'h0, 4'hF, 1'b0, 1, 30, 32'h1234_5678);
      s_bus.resp_valid = 1'b1;
      s_bus.rdata = 32'hCAFE_F00D;
      step();
      step();
      s_bus.resp_valid = 1'b0;
      checks++;
      if (m1_bus.resp_valid !== 1'b0 || m2_bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL late_resp got m1=%b m2=%b want 0 0", m1_bus.resp_valid, m2_bus.resp_valid);
      end
   endtask

   task automatic test_boundary();
      do_txn(1'b0, 1'b1, 32'h0, 32'h8000_5000, 32'h0, 4'hF, 1'b0, 0, TO - 1, 32'hA5A5_0001);
      do_txn(1'b1, 1'b0, 32'h8000_6000, 32'h0, 32'h0, 4'h0, 1'b0, 0, TO, 32'hA5A5_0002);
   endtask

   task automatic test_reset_in_wait();
      m1_bus.req_valid = 1'b1;
      m1_bus.addr = 32'h8000_7000;
      step();
      m1_bus.req_valid = 1'b0;
      s_bus.req_ready = 1'b1;
      step();
      s_bus.req_ready = 1'b0;
      step();
      rst = 1'b1;
      s_bus.resp_valid = 1'b1;
      s_bus.rdata = 32'h1111_2222;
      step();
      checks++;
      if (out_any() !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_wait got nonzero output want all 0");
      end
      rst = 1'b0;
      s_bus.resp_valid = 1'b0;
      last_m2 = 1'b1;
      exp_rd1 = '0;
      exp_rd2 = '0;
      step();
      checks++;
      if (m1_bus.resp_valid !== 1'b0 || s_bus.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got resp=%b sreq=%b want 0 0",
                  m1_bus.resp_valid, s_bus.req_valid);
      end
      do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0000_0413);
   endtask

   task automatic test_random(input int n);
      logic [1:0] v;
      for (int i = 0; i < n; i++) begin
         v = 2'($urandom_range(1, 3));
         do_txn(v[0], v[1], $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 6), $urandom);
      end
   endtask

   initial begin
      m1_bus.req_valid = 1'b0;  m1_bus.addr = '0;  m1_bus.wdata = '0;
      m1_bus.mask = '0;         m1_bus.wen = 1'b0;
      m2_bus.req_valid = 1'b0;  m2_bus.addr = '0;  m2_bus.wdata = '0;
      m2_bus.mask = '0;         m2_bus.wen = 1'b0;
      s_bus.req_ready = 1'b0;   s_bus.resp_valid = 1'b0;
      s_bus.rdata = '0;         s_bus.resp_err = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_reset();
      test_arb();
      test_store();
      test_timeout();
      test_boundary();
      test_reset_in_wait();
      test_random(40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
